tiny_core_mc: RTL

Parametrised multi-cycle successor to the single-cycle tiny core. It fetches 32-bit RV32I-subset instructions over a request/acknowledge instruction-memory port instead of an internal ROM, so fetch may stall. Datapath width, register count, PC width and GPIO width are set by parameters. It adds JAL, BNE, explicit GPIO read/write instructions, a halt state and a retire pulse, and sits directly under the Tiny Tapeout top wrapper.

---
 rtl/tiny_core_mc_if.sv | 12 +
 rtl/tiny_core_mc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/tiny_core_mc_if.sv
// Instruction-memory request/acknowledge port of tiny_core_mc.
interface tiny_core_mc_if #(
  parameter int PC_BITS = 8
) ();
  logic               imem_req;
  logic [PC_BITS-1:0] imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/tiny_core_mc.sv
// tiny_core_mc: multi-cycle RV32I-subset core. FETCH waits for imem_ack,
// EXEC commits one instruction in a single cycle, HALT parks after EBREAK.
module tiny_core_mc #(
  parameter int XLEN    = 32,
  parameter int NREG    = 8,
  parameter int PC_BITS = 8,
  parameter int GPIO_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  tiny_core_mc_if.master    imem,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              retire,
  output logic              halted
);
  localparam int RB = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_CUST   = 7'b0001011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

  state_e              state_q, state_d;
  logic [PC_BITS-1:0]  pc_q, pc_d, pc_nx, pc_plus4;
  logic [31:0]         ir_q;
  logic [XLEN-1:0]     regs_q [NREG];
  logic [GPIO_W-1:0]   sync1_q, sync2_q, gpio_q, gpio_d;

  // Decode fields; register indices keep only the low RB bits so higher ones alias
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [RB-1:0] rs1i, rs2i, wsel;
  logic [31:0]   imm_i, imm_b, imm_j;
  logic [XLEN-1:0] rs1v, rs2v, opb, wdata;
  logic          sub, we, is_ebreak;

  assign opc   = ir_q[6:0];
  assign f3    = ir_q[14:12];
  assign wsel  = ir_q[7 +: RB];
  assign rs1i  = ir_q[15 +: RB];
  assign rs2i  = ir_q[20 +: RB];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // x0 is never written, so reading the array gives zero for it
  assign rs1v      = regs_q[rs1i];
  assign rs2v      = regs_q[rs2i];
  assign sub       = (opc == OPC_OP) && ir_q[30];
  assign opb       = (opc == OPC_OP) ? rs2v : imm_i[XLEN-1:0];
  assign pc_plus4  = pc_q + PC_BITS'(4);
  assign is_ebreak = (ir_q == 32'h0010_0073);

  // Immediate / encoding bits that some parameterisations leave unread
  logic unused_ok;
  assign unused_ok = ^{ir_q, imm_i, imm_b, imm_j};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (imem.imem_ack) state_d = S_EXEC;
      S_EXEC:  state_d = is_ebreak ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // FSM outputs; the request is gated by reset so it drops the moment reset asserts
  always_comb begin
    imem.imem_req = rst_n && (state_q == S_FETCH);
    retire        = (state_q == S_EXEC);
    halted        = (state_q == S_HALT);
  end

  assign imem.imem_addr = pc_q;
  assign gpio_out       = gpio_q;

  // Execute: compute writeback, GPIO and next PC for the instruction in ir_q
  always_comb begin
    we     = 1'b0;
    wdata  = '0;
    gpio_d = gpio_q;
    pc_nx  = pc_plus4;
    case (opc)
      OPC_OPIMM, OPC_OP: begin
        we = 1'b1;
        case (f3)
          3'b000:  wdata = sub ? rs1v - opb : rs1v + opb;
          3'b100:  wdata = rs1v ^ opb;
          3'b110:  wdata = rs1v | opb;
          3'b111:  wdata = rs1v & opb;
          default: we = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        if ((f3 == 3'b000 && rs1v == rs2v) || (f3 == 3'b001 && rs1v != rs2v))
          pc_nx = pc_q + imm_b[PC_BITS-1:0];
      end
      OPC_JAL: begin
        we    = 1'b1;
        wdata = XLEN'(pc_plus4);
        pc_nx = pc_q + imm_j[PC_BITS-1:0];
      end
      OPC_CUST: begin
        case (f3)
          3'b000: gpio_d = rs1v[GPIO_W-1:0];
          3'b001: begin
            we    = 1'b1;
            wdata = XLEN'(sync2_q);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    pc_d = pc_nx & ~PC_BITS'(3);
  end

  // Instruction latch on ack; PC and GPIO commit at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q   <= '0;
      pc_q   <= '0;
      gpio_q <= '0;
    end else if (state_q == S_FETCH && imem.imem_ack) begin
      ir_q <= imem.imem_rdata;
    end else if (state_q == S_EXEC) begin
      pc_q   <= pc_d;
      gpio_q <= gpio_d;
    end
  end

  // Register file writeback; x0 writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (state_q == S_EXEC && we && wsel != '0) begin
      regs_q[wsel] <= wdata;
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end
endmodule
